// File: rtl/block_plotter_if.sv
// Command and pixel bus between the snake controller (master) and block_plotter (slave).
// Carries the command valid/ready handshake and the VGA adapter pixel outputs.
interface block_plotter_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_x;
    logic [6:0] cmd_y;
    logic [2:0] cmd_colour;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       done;

    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_colour,
        input  cmd_ready, x, y, colour, plot, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_colour,
        output cmd_ready, x, y, colour, plot, done
    );
endinterface

// File: rtl/block_plotter.sv
// Expands cell draw/erase and full-screen fill commands into a registered stream
// of single-pixel writes for the VGA adapter, one pixel per clock.
module block_plotter #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int BLOCK    = 2
) (
    input logic            clock,
    input logic            reset,
    block_plotter_if.slave bus
);
    localparam logic [1:0] CELL_LAST   = 2'(BLOCK - 1);
    localparam logic [7:0] FILL_X_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0] FILL_Y_LAST = 7'(SCREEN_H - 1);

    typedef enum logic [1:0] {IDLE, CELL, FILL} state_t;

    state_t     state, state_d;
    logic [1:0] ci, ci_d, cj, cj_d;
    logic [7:0] fx, fx_d;
    logic [6:0] fy, fy_d;
    logic [7:0] bx, bx_d;
    logic [6:0] by, by_d;
    logic [2:0] col, col_d;
    logic [8:0] sx;
    logic [7:0] sy;
    logic       accept;

    logic [7:0] x_p1, x_d;
    logic [6:0] y_p1, y_d;
    logic [2:0] colour_p1, colour_d;
    logic       vld_p1, vld_d;
    logic       done_p1, done_d;

    function automatic logic on_screen(input logic [8:0] px, input logic [7:0] py);
        return (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H));
    endfunction

    // Erase and clear always paint black regardless of the supplied colour.
    function automatic logic [2:0] latch_colour(input logic [1:0] op, input logic [2:0] c);
        return (op == 2'b01 || op == 2'b10) ? 3'b000 : c;
    endfunction

    assign bus.cmd_ready = (state == IDLE) && !reset;
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    always_comb begin
        state_d  = state;
        ci_d     = ci;
        cj_d     = cj;
        fx_d     = fx;
        fy_d     = fy;
        bx_d     = bx;
        by_d     = by;
        col_d    = col;
        x_d      = x_p1;
        y_d      = y_p1;
        colour_d = colour_p1;
        vld_d    = 1'b0;
        done_d   = 1'b0;
        sx       = {1'b0, bx};
        sy       = {1'b0, by};
        unique case (state)
            IDLE: begin
                if (accept) begin
                    bx_d  = bus.cmd_x;
                    by_d  = bus.cmd_y;
                    col_d = latch_colour(bus.cmd_op, bus.cmd_colour);
                    ci_d  = 2'd0;
                    cj_d  = 2'd0;
                    fx_d  = 8'd0;
                    fy_d  = 7'd0;
                    // The first pixel is issued on the accepting edge itself.
                    if (!bus.cmd_op[1]) begin
                        state_d = CELL;
                        sx      = {1'b0, bus.cmd_x};
                        sy      = {1'b0, bus.cmd_y};
                        if (on_screen(sx, sy)) begin
                            vld_d    = 1'b1;
                            x_d      = sx[7:0];
                            y_d      = sy[6:0];
                            colour_d = col_d;
                        end
                    end else begin
                        state_d  = FILL;
                        vld_d    = 1'b1;
                        x_d      = 8'd0;
                        y_d      = 7'd0;
                        colour_d = col_d;
                    end
                end
            end
            CELL: begin
                if (ci == CELL_LAST && cj == CELL_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    if (ci == CELL_LAST) begin
                        ci_d = 2'd0;
                        cj_d = cj + 2'd1;
                    end else begin
                        ci_d = ci + 2'd1;
                    end
                    sx = {1'b0, bx} + {7'd0, ci_d};
                    sy = {1'b0, by} + {6'd0, cj_d};
                    if (on_screen(sx, sy)) begin
                        vld_d    = 1'b1;
                        x_d      = sx[7:0];
                        y_d      = sy[6:0];
                        colour_d = col;
                    end
                end
            end
            FILL: begin
                if (fx == FILL_X_LAST && fy == FILL_Y_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    if (fx == FILL_X_LAST) begin
                        fx_d = 8'd0;
                        fy_d = fy + 7'd1;
                    end else begin
                        fx_d = fx + 8'd1;
                    end
                    vld_d    = 1'b1;
                    x_d      = fx_d;
                    y_d      = fy_d;
                    colour_d = col;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output stage: p1 registers drive the VGA adapter directly.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            vld_p1    <= 1'b0;
            done_p1   <= 1'b0;
            x_p1      <= 8'd0;
            y_p1      <= 7'd0;
            colour_p1 <= 3'd0;
        end else begin
            state     <= state_d;
            vld_p1    <= vld_d;
            done_p1   <= done_d;
            x_p1      <= x_d;
            y_p1      <= y_d;
            colour_p1 <= colour_d;
        end
    end

    always_ff @(posedge clock) begin
        ci  <= ci_d;
        cj  <= cj_d;
        fx  <= fx_d;
        fy  <= fy_d;
        bx  <= bx_d;
        by  <= by_d;
        col <= col_d;
    end

    assign bus.x      = x_p1;
    assign bus.y      = y_p1;
    assign bus.colour = colour_p1;
    assign bus.plot   = vld_p1;
    assign bus.done   = done_p1;
endmodule

// File: tb/tb_block_plotter.sv
// Scoreboard bench for block_plotter: a command-level model queues the expected
// pixel/done events with their cycle stamps, and a monitor compares them as they appear.
module tb_block_plotter;
    localparam int W = 160;
    localparam int H = 120;
    localparam int B = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    block_plotter_if bus();

    block_plotter #(.SCREEN_W(W), .SCREEN_H(H), .BLOCK(B)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int cyc;
        bit is_done;
        int x;
        int y;
        int c;
    } ev_t;

    ev_t q[$];
    int  cyc        = 0;
    int  ready_from = 0;
    int  checks     = 0;
    int  passes     = 0;
    int  last_x     = 0;
    int  last_y     = 0;
    int  last_c     = 0;
    int  visit[W*H];
    ev_t mon_e;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input string act, input string req);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %s, required %s", name, act, req);
    endtask

    // Expected behaviour of one command accepted on edge n, from the pixel rules alone.
    task automatic model_cmd(input int op, input int cx, input int cy, input int c, input int n);
        ev_t e;
        int  k;
        int  col;
        if (op < 2) begin
            col = (op == 1) ? 0 : c;
            for (int j = 0; j < B; j++)
                for (int i = 0; i < B; i++) begin
                    k = j * B + i;
                    if (cx + i < W && cy + j < H) begin
                        e = '{n + k, 1'b0, cx + i, cy + j, col};
                        q.push_back(e);
                    end
                end
            k = B * B;
        end else begin
            col = (op == 2) ? 0 : c;
            for (int p = 0; p < W * H; p++) begin
                e = '{n + p, 1'b0, p % W, p / W, col};
                q.push_back(e);
            end
            k = W * H;
        end
        e = '{n + k, 1'b1, 0, 0, 0};
        q.push_back(e);
        ready_from = n + k;
    endtask

    always @(negedge clock) begin
        if (cyc >= 1) begin
            if (reset) begin
                check(!bus.plot && !bus.done && bus.x == 0 && bus.y == 0 && bus.colour == 0 && !bus.cmd_ready,
                      "reset_state",
                      $sformatf("plot=%0b done=%0b x=%0d y=%0d c=%0d rdy=%0b",
                                bus.plot, bus.done, bus.x, bus.y, bus.colour, bus.cmd_ready),
                      "all zero");
                last_x = 0;
                last_y = 0;
                last_c = 0;
            end else begin
                check(bus.cmd_ready == (cyc >= ready_from), "cmd_ready",
                      $sformatf("%0b at cycle %0d", bus.cmd_ready, cyc),
                      $sformatf("%0b", cyc >= ready_from));
                if (bus.plot || bus.done) begin
                    if (q.size() == 0) begin
                        check(1'b0, "unexpected_output",
                              $sformatf("plot=%0b done=%0b (%0d,%0d) at cycle %0d",
                                        bus.plot, bus.done, bus.x, bus.y, cyc),
                              "no output");
                    end else begin
                        mon_e = q.pop_front();
                        check(mon_e.cyc == cyc && mon_e.is_done == bus.done && !(bus.plot && bus.done) &&
                              (mon_e.is_done || (bus.x == mon_e.x && bus.y == mon_e.y && bus.colour == mon_e.c)),
                              mon_e.is_done ? "done_pulse" : "pixel",
                              $sformatf("cyc=%0d plot=%0b done=%0b (%0d,%0d) c=%0d",
                                        cyc, bus.plot, bus.done, bus.x, bus.y, bus.colour),
                              $sformatf("cyc=%0d done=%0b (%0d,%0d) c=%0d",
                                        mon_e.cyc, mon_e.is_done, mon_e.x, mon_e.y, mon_e.c));
                    end
                end else begin
                    check(bus.x == last_x && bus.y == last_y && bus.colour == last_c, "hold",
                          $sformatf("(%0d,%0d) c=%0d", bus.x, bus.y, bus.colour),
                          $sformatf("(%0d,%0d) c=%0d", last_x, last_y, last_c));
                    if (q.size() > 0 && q[0].cyc <= cyc) begin
                        mon_e = q.pop_front();
                        check(1'b0, "missing_output", $sformatf("nothing at cycle %0d", cyc),
                              $sformatf("done=%0b (%0d,%0d) at cycle %0d",
                                        mon_e.is_done, mon_e.x, mon_e.y, mon_e.cyc));
                    end
                end
                if (bus.plot) begin
                    last_x = bus.x;
                    last_y = bus.y;
                    last_c = bus.colour;
                    if (bus.x < W && bus.y < H) visit[bus.y * W + bus.x]++;
                end
            end
        end
    end

    task automatic send(input int op, input int cx, input int cy, input int c, output int n);
        int t = 0;
        n = -1;
        @(negedge clock); #1;
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = 2'(op);
        bus.cmd_x      = 8'(cx);
        bus.cmd_y      = 7'(cy);
        bus.cmd_colour = 3'(c);
        while (!bus.cmd_ready && t < 25000) begin
            @(negedge clock); #1;
            t++;
        end
        if (!bus.cmd_ready) begin
            check(1'b0, "accept_timeout", "cmd_ready stuck low", "cmd_ready high");
            bus.cmd_valid = 1'b0;
        end else begin
            n = cyc + 1;
            model_cmd(op, cx, cy, c, n);
            @(posedge clock);
        end
    endtask

    task automatic drop();
        @(negedge clock); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (q.size() != 0 && t < 25000) begin
            @(negedge clock);
            t++;
        end
        check(q.size() == 0, "drain", $sformatf("%0d events pending", q.size()), "0 pending");
        repeat (2) @(negedge clock);
    endtask

    task automatic pulse_reset();
        @(negedge clock); #1;
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        q.delete();
        ready_from = 0;
        @(negedge clock); #1;
        reset = 1'b0;
    endtask

    initial begin
        int n1, n2, bad, op, cx, cy;
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 2'd0;
        bus.cmd_x      = 8'd0;
        bus.cmd_y      = 7'd0;
        bus.cmd_colour = 3'd0;
        repeat (3) @(negedge clock);
        #1 reset = 1'b0;

        send(0, 80, 30, 3'b010, n1);
        drop();
        wait_idle();

        send(1, 158, 118, 5, n1);
        send(0, 159, 119, 7, n1);
        drop();
        wait_idle();

        foreach (visit[i]) visit[i] = 0;
        send(2, 33, 44, 7, n1);
        drop();
        wait_idle();
        bad = 0;
        foreach (visit[i]) if (visit[i] != 1) bad++;
        check(bad == 0, "clear_coverage", $sformatf("%0d pixels not visited once", bad), "0");

        // Valid held across a busy cell while cmd_x changes underneath it.
        send(0, 10, 10, 3, n1);
        @(negedge clock); #1;
        bus.cmd_x = 8'd50;
        send(0, 50, 10, 4, n2);
        drop();
        check(n2 - n1 == B * B + 1, "b2b_period", $sformatf("%0d", n2 - n1), $sformatf("%0d", B * B + 1));
        wait_idle();

        repeat (40) begin
            op = $urandom_range(0, 1);
            cx = ($urandom_range(0, 3) == 0) ? $urandom_range(150, 255) : $urandom_range(0, 159);
            cy = ($urandom_range(0, 3) == 0) ? $urandom_range(110, 127) : $urandom_range(0, 119);
            send(op, cx, cy, $urandom_range(0, 7), n1);
            if ($urandom_range(0, 1) == 1) begin
                drop();
                repeat ($urandom_range(0, 3)) @(negedge clock);
            end
        end
        drop();
        wait_idle();

        send(3, 0, 0, 5, n1);
        drop();
        wait_idle();

        send(2, 0, 0, 0, n1);
        drop();
        repeat (500) @(negedge clock);
        pulse_reset();
        repeat (10) @(negedge clock);
        send(0, 0, 0, 6, n1);
        drop();
        wait_idle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/block_plotter.md
# block_plotter

Pixel-sequencing stage between the snake game controller and `vga_adapter`. It accepts one drawing command at a time over a valid/ready handshake and expands it into a stream of single-pixel writes (`x`, `y`, `colour`, `plot`). Two command kinds exist: a BLOCK×BLOCK cell draw/erase with screen-edge clipping, and a full-screen raster fill used for clear/restart. It replaces ad-hoc per-state pixel counters in the controller with one shared, registered pixel source.

## Interface
Parameters:
- `SCREEN_W`, 160, screen width in pixels (x range 0..SCREEN_W-1)
- `SCREEN_H`, 120, screen height in pixels (y range 0..SCREEN_H-1)
- `BLOCK`, 2, cell edge length in pixels; legal range 1..4

Ports:
- `clock` in 1: system clock (CLOCK_50); all logic on its rising edge
- `reset` in 1: **synchronous, active-high** reset, single clock domain
- `cmd_valid` in 1: command present
- `cmd_ready` out 1: block idle and able to accept a command
- `cmd_op` in 2: 00 draw cell, 01 erase cell, 10 clear screen, 11 fill screen with `cmd_colour`
- `cmd_x` in 8: cell top-left x; ignored for ops 10/11
- `cmd_y` in 7: cell top-left y; ignored for ops 10/11
- `cmd_colour` in 3: RGB colour for ops 00/11
- `x` out 8: pixel x to the VGA adapter
- `y` out 7: pixel y to the VGA adapter
- `colour` out 3: pixel colour to the VGA adapter
- `plot` out 1: write strobe to the VGA adapter
- `done` out 1: one-cycle pulse when a command completes

## Operation
- States: IDLE, CELL, FILL.
- `cmd_ready` = (state == IDLE) && !reset. It is combinational.
- A command is accepted on an edge where `cmd_valid && cmd_ready`. On acceptance, op, x, y and colour are latched.
  - Erase (01) latches colour 000.
  - Clear (10) latches colour 000.
- Transitions:
  - IDLE→CELL for op 00/01.
  - IDLE→FILL for op 10/11.
  - CELL→IDLE after BLOCK² pixel cycles.
  - FILL→IDLE after SCREEN_W·SCREEN_H pixel cycles.
- CELL order is row-major: (x+i, y+j), with i the fast index and j the slow index, for i, j in 0..BLOCK-1.
- Clipping: coordinate sums are computed 1 bit wider (9-bit x, 8-bit y). A pixel with sum x ≥ SCREEN_W or sum y ≥ SCREEN_H has `plot`=0, but its cycle is still consumed. A cell with both axes fully off-screen still takes BLOCK² cycles and still pulses `done`.
- FILL order is a raster: x 0..SCREEN_W-1 as the fast index, y 0..SCREEN_H-1 as the slow index. Every pixel is plotted with the latched colour.
- When `plot`=0, `x`, `y` and `colour` hold their last values.
- `cmd_valid` while busy is ignored and not queued. The upstream must hold `cmd_valid` until it sees `cmd_ready`.
- `done` is asserted for exactly one cycle: the first IDLE cycle after the last pixel. A new command may be accepted on that same edge.

## Timing
- Reset values, while `reset` is high and on the following cycle: state IDLE, `x`=0, `y`=0, `colour`=0, `plot`=0, `done`=0.
- `cmd_ready` is 0 while `reset`=1 and 1 on the first cycle after release.
- All pixel outputs are registered.
- For a command accepted at edge N:
  - The first pixel appears in cycle N+1.
  - CELL: pixels in cycles N+1..N+BLOCK², `done` in cycle N+BLOCK²+1.
  - FILL: pixels in cycles N+1..N+19200, `done` in cycle N+19201 at defaults.
- Throughput is one cell command every BLOCK²+1 cycles (5 at defaults).
- Reset mid-command aborts the command immediately:
  - No further pixels are plotted and no `done` pulse is produced.
  - `cmd_ready` returns to 1 the cycle after reset deasserts.
- Counter widths: a 2-bit i/j counter covers BLOCK ≤ 4; FILL counters are 8-bit x and 7-bit y.

## Test plan
- Reset, then op 00 at (80,30) with colour 010. Required: `plot`=1 for 4 cycles at (80,30), (81,30), (80,31), (81,31), all colour 010; `done` pulses in cycle 5; `cmd_ready` is 0 during cycles 1–4.
- op 01 at (158,118). Required: 4 plots at (158,118), (159,118), (158,119), (159,119), colour 000. Then op 00 at (159,119). Required: only the first cycle plots, at (159,119); the next 3 cycles have `plot`=0; `done` still pulses in cycle 5.
- op 10. Required: 19200 consecutive plots, colour 000, starting (0,0), then (1,0)… (159,0), (0,1)… ending (159,119); `done` pulses at cycle 19201; every pixel is visited exactly once (scoreboard).
- Hold `cmd_valid` high with op 00 at (10,10), changing `cmd_x` mid-command. Required: the cell uses the latched (10,10); the next command is accepted on the edge where `done`=1, giving back-to-back commands with a 5-cycle period.
- Assert `reset` for one cycle during FILL (e.g. at pixel 500). Required: `plot`=0 from the next cycle, no `done` pulse, `cmd_ready`=1 after release; a following op 00 at (0,0) completes normally.
